crack_ctrl: RTL and testbench

Key-search sequencer for the ARC4 decryption core. It starts the `arc4` instance once per candidate key and snoops the plaintext write stream while the core runs. It accepts the first key whose decrypted message is entirely printable ASCII. It sits between the top-level task logic and one `arc4` instance, and owns that instance's `en` and `key` inputs.

---
 rtl/crack_pkg.sv | 20 ++
 rtl/crack_ctrl_pt_snoop.sv | 41 ++++
 rtl/crack_ctrl.sv | 113 +++++++++++
 tb/tb_crack_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/crack_pkg.sv
// crack_pkg: shared types and constants for the ARC4 key-search sequencer.
//   crack_state_t - sequencer state encoding
//   KEY_W         - candidate key width (24)
//   PRINT_LO/HI   - inclusive printable ASCII range accepted in plaintext
package crack_pkg;

    localparam int         KEY_W    = 24;
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_A4,
        LAUNCH,
        SETTLE,
        RUN,
        EVAL
    } crack_state_t;

endpackage

// File: rtl/crack_ctrl_pt_snoop.sv
// pt_snoop: watches the arc4 plaintext write stream and flags any message
// byte outside the printable range.
//   clk, rst_n   - clock, synchronous active-low reset
//   clr          - clears len and bad (new candidate / new launch)
//   snoop_en     - writes are only observed while high
//   pt_wren, pt_addr, pt_wrdata - snooped arc4 write port
//   bad          - sticky: a byte at address 1..len was unprintable
module pt_snoop
    import crack_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       snoop_en,
    input  logic       pt_wren,
    input  logic [7:0] pt_addr,
    input  logic [7:0] pt_wrdata,
    output logic       bad
);

    logic [7:0] len;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len <= '0;
            bad <= 1'b0;
        end else if (clr) begin
            len <= '0;
            bad <= 1'b0;
        end else if (snoop_en && pt_wren) begin
            // Address 0 carries the length byte; it is never range-checked.
            // Bytes past len are padding and are ignored.
            if (pt_addr == 8'd0)
                len <= pt_wrdata;
            else if (pt_addr <= len &&
                     (pt_wrdata < PRINT_LO || pt_wrdata > PRINT_HI))
                bad <= 1'b1;
        end
    end

endmodule

// File: rtl/crack_ctrl.sv
// crack_ctrl: key-search sequencer for one arc4 core. Launches the core once
// per candidate key, snoops the plaintext writes, and stops at the first key
// whose message is entirely printable, or after KEY_LAST.
//   clk, rst_n      - clock, synchronous active-low reset (shared with arc4)
//   en / rdy        - start request (taken only while rdy) / idle
//   key, key_valid  - result: last key evaluated, 1 = printable, 0 = exhausted
//   a4_en, a4_key   - arc4 start pulse and key
//   a4_rdy          - arc4 ready
//   pt_wren, pt_addr, pt_wrdata - snooped arc4 plaintext write port
// Build option CRACK_STRIDE2_EN: start at KEY_OFFSET and step by 2, so two
// instances (offset 0 and 1) split the key space. Otherwise start 0, step 1.
module crack_ctrl
    import crack_pkg::*;
#(
    parameter logic [KEY_W-1:0] KEY_OFFSET = '0,
    parameter logic [KEY_W-1:0] KEY_LAST   = 24'hFFFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             rdy,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             a4_en,
    input  logic             a4_rdy,
    output logic [KEY_W-1:0] a4_key,
    input  logic             pt_wren,
    input  logic [7:0]       pt_addr,
    input  logic [7:0]       pt_wrdata
);

`ifdef CRACK_STRIDE2_EN
    localparam logic [KEY_W-1:0] START_KEY = KEY_OFFSET;
    localparam logic [KEY_W:0]   STEP      = (KEY_W+1)'(2);
`else
    localparam logic [KEY_W-1:0] START_KEY = '0;
    localparam logic [KEY_W:0]   STEP      = (KEY_W+1)'(1);
    // KEY_OFFSET only matters for the stride-2 build.
    logic unused_key_offset;
    assign unused_key_offset = ^KEY_OFFSET;
`endif

    crack_state_t     state;
    logic [KEY_W-1:0] cand;
    logic             bad;
    logic             last;
    logic             snoop_clr;

    // Compare with one spare bit so the check cannot wrap; with step 2 a
    // candidate whose successor would overshoot KEY_LAST is the last one.
    assign last = ({1'b0, cand} + STEP) > {1'b0, KEY_LAST};

    assign snoop_clr = (state == IDLE && en) || (state == LAUNCH) ||
                       (state == EVAL && bad && !last);

    assign a4_key = cand;

    pt_snoop u_snoop (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (snoop_clr),
        .snoop_en  (state == RUN),
        .pt_wren   (pt_wren),
        .pt_addr   (pt_addr),
        .pt_wrdata (pt_wrdata),
        .bad       (bad)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rdy       <= 1'b1;
            key       <= '0;
            key_valid <= 1'b0;
            a4_en     <= 1'b0;
            cand      <= '0;
        end else begin
            case (state)
                IDLE: if (en) begin
                    state     <= WAIT_A4;
                    rdy       <= 1'b0;
                    cand      <= START_KEY;
                    key_valid <= 1'b0;
                end
                WAIT_A4: if (a4_rdy) begin
                    state <= LAUNCH;
                    a4_en <= 1'b1;
                end
                LAUNCH: begin
                    state <= SETTLE;
                    a4_en <= 1'b0;
                end
                // The core drops rdy only after seeing the launch; skip one
                // cycle so its still-high rdy is not taken as completion.
                SETTLE: state <= RUN;
                RUN: if (a4_rdy) state <= EVAL;
                EVAL: begin
                    if (!bad || last) begin
                        state     <= IDLE;
                        rdy       <= 1'b1;
                        key       <= cand;
                        key_valid <= !bad;
                    end else begin
                        state <= WAIT_A4;
                        cand  <= cand + STEP[KEY_W-1:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crack_ctrl.sv
// Bench for crack_ctrl with a behavioural arc4 stub driven from a per-key
// message table. Build with or without CRACK_STRIDE2_EN.
module tb_crack_ctrl;

`ifdef CRACK_STRIDE2_EN
    localparam logic [23:0] TB_OFF  = 24'd1;
    localparam logic [23:0] TB_LAST = 24'd7;
    localparam int          TB_STEP = 2;
`else
    localparam logic [23:0] TB_OFF  = 24'd0;
    localparam logic [23:0] TB_LAST = 24'd3;
    localparam int          TB_STEP = 1;
`endif
    localparam int TB_START = int'(TB_OFF);

    logic        clk, rst_n, en, rdy, key_valid, a4_en, a4_rdy, pt_wren;
    logic [23:0] key, a4_key;
    logic [7:0]  pt_addr, pt_wrdata;

    crack_ctrl #(.KEY_OFFSET(TB_OFF), .KEY_LAST(TB_LAST)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key),
        .key_valid(key_valid), .a4_en(a4_en), .a4_rdy(a4_rdy),
        .a4_key(a4_key), .pt_wren(pt_wren), .pt_addr(pt_addr),
        .pt_wrdata(pt_wrdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Message table: msg[k][0] is the length byte, msg_n[k] bytes are written.
    logic [7:0] msg [8][4];
    int         msg_n [8];

    task automatic set_msg(input int k, input int n, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        msg_n[k] = n;
        msg[k][0] = b0; msg[k][1] = b1; msg[k][2] = b2; msg[k][3] = b3;
    endtask

    task automatic all_bad();
        for (int k = 0; k < 8; k++) set_msg(k, 2, 8'h01, 8'h19, 8'h00, 8'h00);
    endtask

    // arc4 stub: on a launch it drops rdy, idles two cycles, writes the key's
    // message one byte per cycle, then raises rdy again.
    logic        stub_busy = 1'b0;
    logic [23:0] stub_key  = '0;
    int          stub_step = 0;
    int          launches  = 0;
    logic [23:0] launched_q [$];

    initial begin
        a4_rdy = 1'b1; pt_wren = 1'b0; pt_addr = '0; pt_wrdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                a4_rdy = 1'b1; pt_wren = 1'b0; stub_busy = 1'b0;
            end else if (!stub_busy) begin
                pt_wren = 1'b0;
                if (a4_en) begin
                    stub_busy = 1'b1; stub_key = a4_key; stub_step = 0;
                    a4_rdy = 1'b0; launches++; launched_q.push_back(a4_key);
                end
            end else begin
                stub_step++;
                if (stub_step >= 2 && stub_step - 2 < msg_n[stub_key[2:0]]) begin
                    pt_wren   = 1'b1;
                    pt_addr   = 8'(stub_step - 2);
                    pt_wrdata = msg[stub_key[2:0]][stub_step - 2];
                end else if (stub_step >= 2) begin
                    pt_wren = 1'b0; a4_rdy = 1'b1; stub_busy = 1'b0;
                end
            end
        end
    end

    // Reference: walk keys start, start+step, ... and stop at the first whose
    // bytes 1..len are all printable, or at the last key not past KEY_LAST.
    function automatic bit msg_good(input int k);
        int len = int'(msg[k][0]);
        for (int a = 1; a <= len && a < msg_n[k] && a < 4; a++)
            if (msg[k][a] < 8'h20 || msg[k][a] > 8'h7E) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model(output logic [23:0] k, output logic v, output int n);
        int c = TB_START;
        n = 0; v = 1'b0; k = '0;
        while (1) begin
            n++; k = 24'(c);
            if (msg_good(c & 7)) begin v = 1'b1; return; end
            if (c + TB_STEP > int'(TB_LAST)) return;
            c += TB_STEP;
        end
    endfunction

    // Per-cycle compare against the current expected result.
    logic        cmp_on = 1'b0;
    logic [23:0] exp_key = '0;
    logic        exp_valid = 1'b0;
    logic        prev_a4en = 1'b0;

    initial forever begin
        @(posedge clk); #1;
        if (rst_n && cmp_on) begin
            if (rdy) begin
                chk("result_key", 32'(key), 32'(exp_key));
                chk("result_valid", 32'(key_valid), 32'(exp_valid));
            end
            chk("a4_en_one_cycle", 32'(prev_a4en && a4_en), 32'd0);
            if (stub_busy) chk("a4_key_stable", 32'(a4_key), 32'(stub_key));
        end
        prev_a4en = a4_en;
    end

    task automatic start_search();
        launches = 0;
        launched_q.delete();
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        chk("rdy_drop", 32'(rdy), 32'd0);
    endtask

    task automatic run_search(input string name, input logic [23:0] hk,
                              input logic hv, input int hl);
        logic [23:0] mk; logic mv; int mn; int t;
        cmp_on = 1'b0;
        model(mk, mv, mn);
        exp_key = mk; exp_valid = mv;
        @(negedge clk);
        start_search();
        cmp_on = 1'b1;
        t = 0;
        while (!rdy && t < 2000) begin @(negedge clk); t++; end
        chk({name, "_timeout"}, 32'(rdy), 32'd1);
        chk({name, "_key"}, 32'(key), 32'(mk));
        chk({name, "_valid"}, 32'(key_valid), 32'(mv));
        chk({name, "_launches"}, 32'(launches), 32'(mn));
        for (int i = 0; i < launched_q.size() && i < mn; i++)
            chk({name, "_launch_key"}, 32'(launched_q[i]), 32'(TB_START + i * TB_STEP));
        // Hand-computed values pin the reference itself.
        chk({name, "_key_lit"}, 32'(mk), 32'(hk));
        chk({name, "_valid_lit"}, 32'(mv), 32'(hv));
        chk({name, "_launches_lit"}, 32'(mn), 32'(hl));
        repeat (3) @(negedge clk);
    endtask

    task automatic reset_mid_run(input logic [23:0] target);
        int t; int n0; logic saw;
        cmp_on = 1'b0;
        all_bad();
        @(negedge clk);
        start_search();
        t = 0;
        while (!(stub_busy && stub_key == target && stub_step >= 3) && t < 2000) begin
            @(negedge clk); t++;
        end
        chk("mid_run_reach", 32'(t < 2000), 32'd1);
        exp_key = '0; exp_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_rdy", 32'(rdy), 32'd1);
        chk("mid_rst_valid", 32'(key_valid), 32'd0);
        chk("mid_rst_key", 32'(key), 32'd0);
        chk("mid_rst_a4en", 32'(a4_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n0 = launches;
        cmp_on = 1'b1;
        saw = 1'b0;
        repeat (20) begin @(negedge clk); if (a4_en) saw = 1'b1; end
        chk("mid_rst_no_a4en", 32'(saw), 32'd0);
        chk("mid_rst_launches", 32'(launches), 32'(n0));
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0;
        all_bad();
        repeat (2) @(negedge clk);
        chk("rst_rdy", 32'(rdy), 32'd1);
        chk("rst_key_valid", 32'(key_valid), 32'd0);
        chk("rst_a4_en", 32'(a4_en), 32'd0);
        chk("rst_a4_key", 32'(a4_key), 32'd0);
        chk("rst_key", 32'(key), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef CRACK_STRIDE2_EN
        all_bad();
        set_msg(5, 2, 8'h01, 8'h41, 8'h00, 8'h00);
        run_search("stride", 24'd5, 1'b1, 3);

        all_bad();
        set_msg(1, 3, 8'h02, 8'h20, 8'h7E, 8'h00);
        run_search("edge_accept", 24'd1, 1'b1, 1);

        all_bad();
        run_search("exhaust", 24'd7, 1'b0, 4);

        reset_mid_run(24'd3);

        all_bad();
        set_msg(3, 2, 8'h01, 8'h7E, 8'h00, 8'h00);
        run_search("recover", 24'd3, 1'b1, 2);
`else
        all_bad();
        set_msg(2, 4, 8'h03, 8'h41, 8'h42, 8'h43);
        set_msg(3, 2, 8'h01, 8'h41, 8'h00, 8'h00);
        run_search("first_good", 24'd2, 1'b1, 3);

        all_bad();
        set_msg(0, 3, 8'h02, 8'h20, 8'h7E, 8'h00);
        run_search("edge_accept", 24'd0, 1'b1, 1);

        all_bad();
        set_msg(0, 2, 8'h01, 8'h1F, 8'h00, 8'h00);
        set_msg(1, 2, 8'h01, 8'h7F, 8'h00, 8'h00);
        set_msg(2, 2, 8'h01, 8'h41, 8'h00, 8'h00);
        run_search("edge_reject", 24'd2, 1'b1, 3);

        all_bad();
        set_msg(0, 4, 8'h02, 8'h41, 8'h42, 8'h7F);
        run_search("beyond_len", 24'd0, 1'b1, 1);

        all_bad();
        run_search("exhaust", 24'd3, 1'b0, 4);

        reset_mid_run(24'd1);

        all_bad();
        set_msg(2, 4, 8'h03, 8'h41, 8'h42, 8'h43);
        run_search("recover", 24'd2, 1'b1, 3);
`endif

        cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
